// File: rtl/spi_frame_master.sv
// SPI frame master: each command becomes one {rw, addr, data} frame, MSB first, on one chip select.
// Optional macro SPI_FRAME_MASTER_LOOPBACK_EN samples the internal MOSI register instead of the MISO pin.
module spi_frame_master #(
  parameter int CPOL   = 0,
  parameter int CPHA   = 0,
  parameter int SLAVES = 1,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DIV    = 4,
  localparam int SW    = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [SW-1:0]     cmd_slave,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              abort,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              SCLK,
  output logic [SLAVES-1:0] SS,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int N  = 1 + ADDR_W + DATA_W;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW = $clog2(2 * N);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(2 * N - 1);
  localparam logic          SCLK_IDLE = 1'(CPOL);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     div_reg, div_next;
  logic [HW-1:0]     half_reg, half_next;
  logic [N-1:0]      frame_reg, frame_next;
  logic [DATA_W-1:0] rx_reg, rx_next;
  logic              write_reg, write_next;
  logic              sclk_reg, sclk_next;
  logic [SLAVES-1:0] ss_reg, ss_next;
  logic              mosi_reg, mosi_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic              rsp_err_reg, rsp_err_next;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;

  logic [SLAVES-1:0] sel_dec;
  logic              bad_slave;
  logic              div_done;
  logic              leading;
  logic              last_half;
  logic              do_sample;
  logic              do_advance;
  logic              sample_bit;

  for (genvar gi = 0; gi < SLAVES; gi++) begin : g_sel
    assign sel_dec[gi] = (cmd_slave == SW'(gi));
  end

  assign bad_slave = ({1'b0, cmd_slave} >= (SW + 1)'(SLAVES));
  assign div_done  = (div_reg == '0);
  // Even half-periods end in a leading edge (away from the idle level).
  assign leading   = ~half_reg[0];
  assign last_half = (half_reg == HALF_LAST);

  assign do_sample  = (CPHA == 0) ? leading : ~leading;
  assign do_advance = (CPHA == 0) ? (~leading && !last_half)
                                  : (leading && (half_reg != '0));

`ifdef SPI_FRAME_MASTER_LOOPBACK_EN
  assign sample_bit = mosi_reg;
`else
  assign sample_bit = MISO;
`endif

  always_comb begin
    state_next     = state_reg;
    div_next       = div_reg;
    half_next      = half_reg;
    frame_next     = frame_reg;
    rx_next        = rx_reg;
    write_next     = write_reg;
    sclk_next      = sclk_reg;
    ss_next        = ss_reg;
    mosi_next      = mosi_reg;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_rdata_next = '0;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          if (bad_slave) begin
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
          end else begin
            state_next = SETUP;
            div_next   = DIV_LOAD;
            half_next  = '0;
            rx_next    = '0;
            write_next = cmd_write;
            ss_next    = ~sel_dec;
            frame_next = {cmd_write, cmd_addr, cmd_write ? cmd_wdata : {DATA_W{1'b0}}};
            mosi_next  = cmd_write;
          end
        end
      end
      SETUP: begin
        if (div_done) begin
          state_next = SHIFT;
          div_next   = DIV_LOAD;
        end else begin
          div_next = div_reg - CW'(1);
        end
      end
      SHIFT: begin
        if (div_done) begin
          div_next  = DIV_LOAD;
          sclk_next = ~sclk_reg;
          half_next = half_reg + HW'(1);
          // Every sample is shifted in; the final DATA_W samples are the data field.
          if (do_sample) begin
            rx_next = DATA_W'({rx_reg, sample_bit});
          end
          if (do_advance) begin
            frame_next = {frame_reg[N-2:0], 1'b0};
            mosi_next  = frame_reg[N-2];
          end
          if (last_half) begin
            state_next = HOLD;
          end
        end else begin
          div_next = div_reg - CW'(1);
        end
      end
      HOLD: begin
        if (div_done) begin
          state_next     = GAP;
          div_next       = DIV_LOAD;
          ss_next        = '1;
          mosi_next      = 1'b0;
          rsp_valid_next = 1'b1;
`ifdef SPI_FRAME_MASTER_LOOPBACK_EN
          rsp_rdata_next = rx_reg;
`else
          rsp_rdata_next = write_reg ? '0 : rx_reg;
`endif
        end else begin
          div_next = div_reg - CW'(1);
        end
      end
      GAP: begin
        if (div_done) begin
          state_next = IDLE;
        end else begin
          div_next = div_reg - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (abort && (state_reg == SETUP || state_reg == SHIFT || state_reg == HOLD)) begin
      state_next     = GAP;
      div_next       = DIV_LOAD;
      sclk_next      = SCLK_IDLE;
      ss_next        = '1;
      mosi_next      = 1'b0;
      rsp_valid_next = 1'b1;
      rsp_err_next   = 1'b1;
      rsp_rdata_next = '0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_reg     <= IDLE;
      div_reg       <= '0;
      half_reg      <= '0;
      frame_reg     <= '0;
      rx_reg        <= '0;
      write_reg     <= 1'b0;
      sclk_reg      <= SCLK_IDLE;
      ss_reg        <= '1;
      mosi_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      div_reg       <= div_next;
      half_reg      <= half_next;
      frame_reg     <= frame_next;
      rx_reg        <= rx_next;
      write_reg     <= write_next;
      sclk_reg      <= sclk_next;
      ss_reg        <= ss_next;
      mosi_reg      <= mosi_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_rdata_reg <= rsp_rdata_next;
    end
  end

  assign cmd_ready = (state_reg == IDLE) & ~PRESET;
  assign busy      = (state_reg != IDLE);
  assign SCLK      = sclk_reg;
  assign SS        = ss_reg;
  assign MOSI      = mosi_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule
